// File: rtl/discus_loader.sv
// Framed-byte loader for the discus snoop port: program/data writes and data readback.
// Define DISCUS_LOADER_CHECKSUM_EN to append a mod-256 payload checksum byte to every op.
module discus_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] snoopa,
  output logic [7:0] snoopd,
  output logic       snoopm,
  output logic       snoopp,
  input  logic [7:0] snoopq,
  output logic       busy
);

  localparam logic [1:0] OP_PWRITE = 2'b00;
  localparam logic [1:0] OP_DWRITE = 2'b01;
  localparam logic [1:0] OP_DREAD  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

`ifdef DISCUS_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR, ST_CNT, ST_WDATA, ST_RISSUE, ST_RCAP, ST_RSEND, ST_SUM
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR, ST_CNT, ST_WDATA, ST_RISSUE, ST_RCAP, ST_RSEND
  } state_e;
`endif

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] snoopa_q, snoopa_d;
  logic [7:0] snoopd_q, snoopd_d;
  logic       snoopm_q, snoopm_d;
  logic       snoopp_q, snoopp_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       busy_q;
`ifdef DISCUS_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CMD;
      op_q       <= OP_PWRITE;
      addr_q     <= 8'h00;
      cnt_q      <= 9'd0;
      snoopa_q   <= 8'h00;
      snoopd_q   <= 8'h00;
      snoopm_q   <= 1'b0;
      snoopp_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef DISCUS_LOADER_CHECKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      snoopa_q   <= snoopa_d;
      snoopd_q   <= snoopd_d;
      snoopm_q   <= snoopm_d;
      snoopp_q   <= snoopp_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= (state_d != ST_CMD);
`ifdef DISCUS_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // snoopa is loaded on entry to RISSUE so snoopq is valid by RCAP
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    snoopa_d   = snoopa_q;
    snoopd_d   = snoopd_q;
    snoopm_d   = 1'b0;
    snoopp_d   = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
`ifdef DISCUS_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      ST_CMD: if (rx_valid) begin
        op_d = rx_data[7:6];
        if (rx_data[7:6] != OP_RSVD) state_d = ST_ADDR;
      end
      ST_ADDR: if (rx_valid) begin
        addr_d  = rx_data;
        state_d = ST_CNT;
      end
      ST_CNT: if (rx_valid) begin
        cnt_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
`ifdef DISCUS_LOADER_CHECKSUM_EN
        sum_d = 8'h00;
`endif
        if (op_q == OP_DREAD) begin
          state_d  = ST_RISSUE;
          snoopa_d = addr_q;
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_WDATA: if (rx_valid) begin
        snoopa_d = addr_q;
        snoopd_d = rx_data;
        snoopp_d = (op_q == OP_PWRITE);
        snoopm_d = (op_q == OP_DWRITE);
        addr_d   = addr_q + 8'd1;
        cnt_d    = cnt_q - 9'd1;
`ifdef DISCUS_LOADER_CHECKSUM_EN
        sum_d = sum_q + rx_data;
        if (cnt_q == 9'd1) begin
          state_d    = ST_SUM;
          tx_data_d  = sum_d;
          tx_valid_d = 1'b1;
        end
`else
        if (cnt_q == 9'd1) state_d = ST_CMD;
`endif
      end
      ST_RISSUE: state_d = ST_RCAP;
      ST_RCAP: begin
        tx_data_d  = snoopq;
        tx_valid_d = 1'b1;
`ifdef DISCUS_LOADER_CHECKSUM_EN
        sum_d = sum_q + snoopq;
`endif
        state_d = ST_RSEND;
      end
      ST_RSEND: if (tx_ready) begin
        tx_valid_d = 1'b0;
        addr_d     = addr_q + 8'd1;
        snoopa_d   = addr_q + 8'd1;
        cnt_d      = cnt_q - 9'd1;
        if (cnt_q != 9'd1) begin
          state_d = ST_RISSUE;
        end else begin
`ifdef DISCUS_LOADER_CHECKSUM_EN
          state_d    = ST_SUM;
          tx_data_d  = sum_q;
          tx_valid_d = 1'b1;
`else
          state_d = ST_CMD;
`endif
        end
      end
`ifdef DISCUS_LOADER_CHECKSUM_EN
      ST_SUM: if (tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = ST_CMD;
      end
`endif
      default: state_d = ST_CMD;
    endcase
  end

  assign rx_ready = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                    (state_q == ST_CNT) || (state_q == ST_WDATA);
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign snoopa   = snoopa_q;
  assign snoopd   = snoopd_q;
  assign snoopm   = snoopm_q;
  assign snoopp   = snoopp_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_discus_loader.sv
// Directed bench for discus_loader with a snoop memory model and rx/tx/strobe monitors.
// Honours DISCUS_LOADER_CHECKSUM_EN for the extra checksum byte expectations.
module tb_discus_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] snoopa;
  logic [7:0] snoopd;
  logic       snoopm;
  logic       snoopp;
  logic [7:0] snoopq;
  logic       busy;

  logic [7:0]  mem [256];
  logic [15:0] pQ[$];
  logic [15:0] mQ[$];
  logic [7:0]  txQ[$];
  int          bothCount = 0;
  int          errCount = 0;
  int          checkCount = 0;

  discus_loader dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .snoopa(snoopa), .snoopd(snoopd), .snoopm(snoopm), .snoopp(snoopp),
    .snoopq(snoopq), .busy(busy)
  );

  always #5 clk = ~clk;

  // Data memory with a registered read port, as the core presents it
  always @(posedge clk) begin
    if (snoopm) mem[snoopa] <= snoopd;
    snoopq <= mem[snoopa];
  end

  always @(negedge clk) begin
    if (snoopp) pQ.push_back({snoopa, snoopd});
    if (snoopm) mQ.push_back({snoopa, snoopd});
    if (snoopm && snoopp) bothCount++;
    if (tx_valid && tx_ready) txQ.push_back(tx_data);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) checkOutput("rx_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= limit) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic clearQueues();
    pQ.delete();
    mQ.delete();
    txQ.delete();
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    #12;
    checkOutput("rst_snoopa", snoopa, 8'h00);
    checkOutput("rst_snoopd", snoopd, 8'h00);
    checkOutput("rst_strobes", {snoopm, snoopp}, 2'b00);
    checkOutput("rst_tx", {tx_valid, tx_data}, 9'h000);
    checkOutput("rst_rx_ready", rx_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Program write of three bytes at 0x10
    clearQueues();
    applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h03);
    checkOutput("pw_busy", busy, 1'b1);
    applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC);
    waitCycles(4);
    checkOutput("pw_count", pQ.size(), 3);
    if (pQ.size() == 3) begin
      checkOutput("pw_0", pQ[0], 16'h10AA);
      checkOutput("pw_1", pQ[1], 16'h11BB);
      checkOutput("pw_2", pQ[2], 16'h12CC);
    end
    checkOutput("pw_no_m", mQ.size(), 0);
`ifdef DISCUS_LOADER_CHECKSUM_EN
    checkOutput("pw_tx_count", txQ.size(), 1);
    if (txQ.size() == 1) checkOutput("pw_sum", txQ[0], 8'h31);
`else
    checkOutput("pw_tx_count", txQ.size(), 0);
`endif
    checkOutput("pw_idle", busy, 1'b0);

    // Data write wrapping past 0xFF
    clearQueues();
    applyStimulus(8'h40); applyStimulus(8'hFE); applyStimulus(8'h03);
    applyStimulus(8'h01);
    waitCycles(3);
    applyStimulus(8'h02); applyStimulus(8'h03);
    waitCycles(4);
    checkOutput("wr_count", mQ.size(), 3);
    if (mQ.size() == 3) begin
      checkOutput("wr_0", mQ[0], 16'hFE01);
      checkOutput("wr_1", mQ[1], 16'hFF02);
      checkOutput("wr_2", mQ[2], 16'h0003);
    end
    checkOutput("wr_no_p", pQ.size(), 0);
    checkOutput("wr_mem00", mem[0], 8'h03);

    // Preload 0x20/0x21, then read back under backpressure
    applyStimulus(8'h40); applyStimulus(8'h20); applyStimulus(8'h02);
    applyStimulus(8'h5A); applyStimulus(8'hA5);
    waitCycles(4);
    waitIdle(50);
    clearQueues();
    tx_ready = 1'b0;
    applyStimulus(8'h80); applyStimulus(8'h20); applyStimulus(8'h02);
    checkOutput("rd_rx_ready", rx_ready, 1'b0);
    n = 0;
    while (!tx_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("rd_valid_lat", n, 2);
    for (int i = 0; i < 5; i++) begin
      waitCycles(1);
      checkOutput("rd_hold", {tx_valid, tx_data}, 9'h15A);
    end
    tx_ready = 1'b1;
    waitCycles(20);
`ifdef DISCUS_LOADER_CHECKSUM_EN
    checkOutput("rd_count", txQ.size(), 3);
    if (txQ.size() == 3) checkOutput("rd_sum", txQ[2], 8'hFF);
`else
    checkOutput("rd_count", txQ.size(), 2);
`endif
    if (txQ.size() >= 2) begin
      checkOutput("rd_0", txQ[0], 8'h5A);
      checkOutput("rd_1", txQ[1], 8'hA5);
    end
    checkOutput("rd_idle", busy, 1'b0);

    // 256-byte read starting at 0x00
    clearQueues();
    applyStimulus(8'h80); applyStimulus(8'h00); applyStimulus(8'h00);
    waitIdle(3000);
    waitCycles(2);
`ifdef DISCUS_LOADER_CHECKSUM_EN
    checkOutput("full_count", txQ.size(), 257);
`else
    checkOutput("full_count", txQ.size(), 256);
`endif
    checkOutput("full_snoopa", snoopa, 8'h00);
    if (txQ.size() >= 256) begin
      checkOutput("full_00", txQ[0], 8'h03);
      checkOutput("full_20", txQ[32], 8'h5A);
      checkOutput("full_21", txQ[33], 8'hA5);
      checkOutput("full_ff", txQ[255], 8'h02);
    end

    // Reserved command is swallowed, next frame runs normally
    clearQueues();
    applyStimulus(8'hC0);
    checkOutput("rsv_busy", busy, 1'b0);
    waitCycles(5);
    checkOutput("rsv_busy_late", busy, 1'b0);
    checkOutput("rsv_no_tx", txQ.size(), 0);
    applyStimulus(8'h00); applyStimulus(8'h05); applyStimulus(8'h01);
    applyStimulus(8'h77);
    waitCycles(4);
    checkOutput("rsv_pw_count", pQ.size(), 1);
    if (pQ.size() == 1) checkOutput("rsv_pw", pQ[0], 16'h0577);

    // Reset while the second data byte's strobe is high
    clearQueues();
    applyStimulus(8'h40); applyStimulus(8'h30); applyStimulus(8'h04);
    applyStimulus(8'h11); applyStimulus(8'h22);
    checkOutput("mid_strobe", {snoopm, snoopa, snoopd}, 17'h13122);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_strobes", {snoopm, snoopp}, 2'b00);
    checkOutput("mid_rst_snoop", {snoopa, snoopd}, 16'h0000);
    checkOutput("mid_rst_state", {busy, rx_ready, tx_valid}, 3'b010);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_m_count", mQ.size(), 1);
    checkOutput("mid_mem30", mem[8'h30], 8'h11);
    applyStimulus(8'h00); applyStimulus(8'h40); applyStimulus(8'h01);
    applyStimulus(8'h99);
    waitCycles(4);
    checkOutput("mid_new_count", pQ.size(), 1);
    if (pQ.size() == 1) checkOutput("mid_new", pQ[0], 16'h4099);

    checkOutput("strobe_excl", bothCount, 0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got 1 expected 0");
    $fatal(1, "[TB] timeout");
  end

endmodule
